// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: shared state encoding and helpers for the FIFO write-port arbiter
package fifo_wr_arbiter_pkg;
  localparam int MAX_REQ = 8;
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
  function automatic int cnt_width(int burst_max);
    return $clog2(burst_max + 1);
  endfunction
  // first set bit of req searching upward from ptr+1, wrapping modulo n
  function automatic logic [MAX_REQ-1:0] rotate_pick(logic [MAX_REQ-1:0] req, logic [2:0] ptr, int n);
    logic [MAX_REQ-1:0] oh;
    logic [3:0] s;
    oh = '0;
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        s = {1'b0, ptr} + 4'(i);
        if (s >= 4'(n)) s = s - 4'(n);
        if (req[s[2:0]]) begin
          oh = '0;
          oh[s[2:0]] = 1'b1;
        end
      end
    end
    return oh;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake plus FIFO write-port bundle
interface fifo_wr_arbiter_if #(parameter int DATA_WIDTH = 32, parameter int N_REQ = 4);
  logic [N_REQ-1:0] REQ_VALID;
  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [N_REQ-1:0] REQ_READY;
  logic [N_REQ-1:0] GRANT;
  logic FIFO_WEN;
  logic [DATA_WIDTH-1:0] FIFO_WDATA;
  logic FIFO_WFULL;
  logic BUSY;
  modport slave (input REQ_VALID, REQ_DATA, FIFO_WFULL, output REQ_READY, GRANT, FIFO_WEN, FIFO_WDATA, BUSY);
  modport master (output REQ_VALID, REQ_DATA, FIFO_WFULL, input REQ_READY, GRANT, FIFO_WEN, FIFO_WDATA, BUSY);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// fifo_rr_pick: combinational round-robin winner select from a request vector and last-winner pointer
module fifo_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          found
);
  logic [MAX_REQ-1:0] oh;
  always_comb begin
    oh = rotate_pick(MAX_REQ'(req), 3'(ptr), N);
    onehot = oh[N-1:0];
    found = |oh;
    idx = '0;
    for (int i = 0; i < N; i++) idx = oh[i] ? PW'(i) : idx;
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among N_REQ requesters
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int BURST_MAX = 4
) (
  input logic HCLK,
  input logic HRESETn,
  fifo_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = cnt_width(BURST_MAX);
  state_t state;
  logic [N_REQ-1:0] grant, pick_req, pick_oh;
  logic [PW-1:0] ptr, pick_idx;
  logic [CW-1:0] cnt;
  logic busy, vg, xfer, rel_a, rel_b, reload, found;
  logic [DATA_WIDTH-1:0] wdata;
  // a full FIFO freezes the burst: no transfer, no release
  always_comb begin
    busy = state == ST_GRANT;
    vg = |(bus.REQ_VALID & grant);
    xfer = busy & vg & ~bus.FIFO_WFULL;
    rel_a = xfer & (cnt + CW'(1) == CW'(BURST_MAX));
    rel_b = busy & ~vg & ~bus.FIFO_WFULL;
    reload = ~busy | rel_a | rel_b;
    pick_req = bus.REQ_VALID & ~(rel_b ? grant : '0);
  end
  fifo_rr_pick #(.N(N_REQ)) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .onehot(pick_oh),
    .idx(pick_idx),
    .found(found)
  );
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      grant <= '0;
      cnt <= '0;
      ptr <= PW'(N_REQ - 1);
    end else if (reload) begin
      state <= found ? ST_GRANT : ST_IDLE;
      grant <= found ? pick_oh : '0;
      cnt <= '0;
      ptr <= found ? pick_idx : ptr;
    end else if (xfer) begin
      cnt <= cnt + CW'(1);
    end
  end
  always_comb begin
    wdata = '0;
    for (int i = 0; i < N_REQ; i++) wdata = wdata | (grant[i] ? bus.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH] : '0);
  end
  // outputs are masked while reset is low so a word in the reset cycle is never written
  assign bus.GRANT = grant;
  assign bus.BUSY = busy;
  assign bus.FIFO_WEN = xfer & HRESETn;
  assign bus.REQ_READY = grant & {N_REQ{~bus.FIFO_WFULL & HRESETn}};
  assign bus.FIFO_WDATA = wdata;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven grant checks, per-requester data scoreboard and an end-to-end FIFO run
module tb_fifo_wr_arbiter;
  logic HCLK = 0, HRESETn = 0, rclk = 0;
  fifo_wr_arbiter_if #(.DATA_WIDTH(32), .N_REQ(4)) bus();
  fifo_wr_arbiter #(.DATA_WIDTH(32), .N_REQ(4), .BURST_MAX(4)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
  always #5 HCLK = ~HCLK;
  initial begin
    #3;
    forever #10 rclk = ~rclk;
  end
  typedef struct {logic [3:0] en; logic full; logic [3:0] grant; logic wen;} vec_t;
  vec_t tbl[$];
  logic [31:0] wq[4][$];
  logic [31:0] ex[4][$];
  logic [31:0] mem[8];
  logic [31:0] rd_log[16];
  logic [31:0] wd_s;
  logic [3:0] en = 0, xf = 0;
  logic force_full = 0, wen_s = 0, e2e = 0, rd_go = 0;
  int tests = 0, fails = 0, wr_cnt = 0, rd_cnt = 0, full_seen = 0;
  // behavioural stand-in for the 8-deep dual-clock FIFO; read side starts once it first fills
  assign bus.FIFO_WFULL = e2e ? (wr_cnt - rd_cnt >= 8) : force_full;
  always @(posedge rclk) begin
    if (e2e && bus.FIFO_WFULL) rd_go <= 1'b1;
    if (e2e && (rd_go || bus.FIFO_WFULL) && rd_cnt != wr_cnt && rd_cnt < 16) begin
      rd_log[rd_cnt] <= mem[rd_cnt % 8];
      rd_cnt <= rd_cnt + 1;
    end
  end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic push(int i, logic [31:0] w);
    wq[i].push_back(w);
    ex[i].push_back(w);
  endtask
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.REQ_VALID[i] = en[i] && wq[i].size() > 0;
      bus.REQ_DATA[i*32 +: 32] = wq[i].size() > 0 ? wq[i][0] : 32'h0;
    end
  endtask
  task automatic tick();
    int g;
    @(negedge HCLK);
    if (bus.FIFO_WFULL) full_seen++;
    xf = bus.REQ_VALID & bus.REQ_READY;
    wen_s = bus.FIFO_WEN;
    wd_s = bus.FIFO_WDATA;
    if (wen_s) begin
      g = -1;
      for (int i = 0; i < 4; i++) if (bus.GRANT[i]) g = i;
      if (g < 0 || ex[g].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got wen with grant %b, required no write", bus.GRANT);
      end else chk("sb_data", wd_s, ex[g].pop_front());
    end
  endtask
  task automatic adv();
    @(posedge HCLK);
    #1;
    for (int i = 0; i < 4; i++) if (xf[i]) void'(wq[i].pop_front());
    if (e2e && wen_s) begin
      mem[wr_cnt % 8] = wd_s;
      wr_cnt++;
    end
    drive();
  endtask
  task automatic add(logic [3:0] e, logic f, logic [3:0] g, logic w, int n);
    for (int k = 0; k < n; k++) tbl.push_back('{e, f, g, w});
  endtask
  task automatic do_reset();
    HRESETn = 0;
    tick();
    adv();
    HRESETn = 1;
  endtask
  initial begin
    int nx[2];
    int id;
    bus.REQ_VALID = 0;
    bus.REQ_DATA = 0;
    tick();
    chk("rst_grant", 32'(bus.GRANT), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_wen", 32'(bus.FIFO_WEN), 0);
    chk("rst_ready", 32'(bus.REQ_READY), 0);
    adv();
    HRESETn = 1;
    // single requester, three words then a gap
    push(1, 32'hAAAABBBB);
    push(1, 32'hBBBBCCCC);
    push(1, 32'hCCCCDDDD);
    en = 4'b0010;
    drive();
    tick();
    chk("t1_arb_grant", 32'(bus.GRANT), 0);
    chk("t1_arb_wen", 32'(bus.FIFO_WEN), 0);
    adv();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_grant", 32'(bus.GRANT), 32'b0010);
      chk("t1_wen", 32'(bus.FIFO_WEN), 1);
      adv();
    end
    tick();
    chk("t1_gap_wen", 32'(bus.FIFO_WEN), 0);
    adv();
    tick();
    chk("t1_idle_busy", 32'(bus.BUSY), 0);
    chk("t1_idle_grant", 32'(bus.GRANT), 0);
    chk("t1_drained", 32'(ex[1].size()), 0);
    adv();
    // table: fair bursts, WFULL stall inside requester 1, requester 2 gap
    en = 0;
    drive();
    do_reset();
    for (int i = 0; i < 4; i++) for (int k = 0; k < 32; k++) push(i, {8'(i), 24'(k)});
    add(4'b1111, 0, 4'b0000, 0, 1);
    add(4'b1111, 0, 4'b0001, 1, 4);
    add(4'b1111, 0, 4'b0010, 1, 4);
    add(4'b1111, 0, 4'b0100, 1, 4);
    add(4'b1111, 0, 4'b1000, 1, 4);
    add(4'b1111, 0, 4'b0001, 1, 4);
    add(4'b1111, 0, 4'b0010, 1, 2);
    add(4'b1111, 1, 4'b0010, 0, 5);
    add(4'b1111, 0, 4'b0010, 1, 2);
    add(4'b1111, 0, 4'b0100, 1, 1);
    add(4'b0011, 0, 4'b0100, 0, 1);
    add(4'b0011, 0, 4'b0001, 1, 4);
    add(4'b0011, 0, 4'b0010, 1, 1);
    foreach (tbl[r]) begin
      en = tbl[r].en;
      force_full = tbl[r].full;
      drive();
      tick();
      chk($sformatf("tbl%0d_grant", r), 32'(bus.GRANT), 32'(tbl[r].grant));
      chk($sformatf("tbl%0d_wen", r), 32'(bus.FIFO_WEN), 32'(tbl[r].wen));
      chk($sformatf("tbl%0d_ready", r), 32'(bus.REQ_READY), 32'(tbl[r].full ? 4'b0000 : tbl[r].grant));
      chk($sformatf("tbl%0d_busy", r), 32'(bus.BUSY), 32'(tbl[r].grant != 0));
      adv();
    end
    // reset pulse in the middle of a requester 3 burst
    en = 4'b1000;
    force_full = 0;
    drive();
    tick();
    chk("rb_gap_wen", 32'(bus.FIFO_WEN), 0);
    adv();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rb_grant3", 32'(bus.GRANT), 32'b1000);
      chk("rb_wen", 32'(bus.FIFO_WEN), 1);
      adv();
    end
    HRESETn = 0;
    tick();
    chk("rb_rst_wen", 32'(bus.FIFO_WEN), 0);
    chk("rb_rst_ready", 32'(bus.REQ_READY), 0);
    adv();
    HRESETn = 1;
    en = 4'b1001;
    drive();
    tick();
    chk("rb_after_grant", 32'(bus.GRANT), 0);
    chk("rb_after_busy", 32'(bus.BUSY), 0);
    adv();
    tick();
    chk("rb_first_win", 32'(bus.GRANT), 32'b0001);
    adv();
    // end to end through the FIFO model with WFULL back-pressure
    en = 0;
    drive();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wq[i].delete();
      ex[i].delete();
    end
    full_seen = 0;
    e2e = 1;
    for (int k = 0; k < 8; k++) begin
      push(0, {8'hE0, 24'(k)});
      push(1, {8'hE1, 24'(k)});
    end
    en = 4'b0011;
    drive();
    for (int c = 0; c < 600 && rd_cnt < 16; c++) begin
      tick();
      adv();
    end
    chk("e2e_count", 32'(rd_cnt), 16);
    chk("e2e_full_seen", 32'(full_seen > 0), 1);
    nx = '{0, 0};
    for (int k = 0; k < rd_cnt && k < 16; k++) begin
      id = int'(rd_log[k][31:24]) - 'hE0;
      if (id < 0 || id > 1) chk("e2e_id", rd_log[k], 32'hE0000000);
      else begin
        chk("e2e_order", 32'(rd_log[k][23:0]), 32'(nx[id]));
        nx[id]++;
      end
    end
    chk("e2e_r0_words", 32'(nx[0]), 8);
    chk("e2e_r1_words", 32'(nx[1]), 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter and sequencer for the write port of the dual-clock FIFO (mfp_fifo_dc, write side).
- Shares one FIFO write port between N_REQ requesters, e.g. AHB write-data buffer, refresh/log sources, DMA.
- Grants one requester at a time for a burst of up to BURST_MAX words.
- Drives WEN/WDATA and honours WFULL.
- Lives entirely in the FIFO write-clock domain.

Parameters:
- DATA_WIDTH, 32, width of one FIFO word.
- N_REQ, 4, number of requesters (2..8).
- BURST_MAX, 4, maximum words transferred per grant before forced re-arbitration (1..16).

Ports:
- HCLK  in  1  clock; the same clock as the FIFO WCLK.
- HRESETn  in  1  synchronous reset, active-low, sampled on rising HCLK.
- REQ_VALID  in  N_REQ  per-requester word valid.
- REQ_DATA  in  N_REQ*DATA_WIDTH  per-requester word; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ_READY  out  N_REQ  per-requester accept; a word transfers when VALID&READY at rising HCLK.
- GRANT  out  N_REQ  one-hot registered grant; all-zero when idle.
- FIFO_WEN  out  1  to FIFO WEN.
- FIFO_WDATA  out  DATA_WIDTH  to FIFO WDATA.
- FIFO_WFULL  in  1  from FIFO WFULL.
- BUSY  out  1  high while any grant is held.

Behaviour:
- Reset (HRESETn=0 at rising edge): state=IDLE, GRANT=0, burst count=0, rr pointer=N_REQ-1 so requester 0 wins first. REQ_READY=0, FIFO_WEN=0, BUSY=0 follow combinationally. FIFO_WDATA is don't-care while FIFO_WEN=0 and is driven 0 when no grant is held.
- States: IDLE, GRANT.
- IDLE:
  - If any REQ_VALID bit is high, the winner is the first set bit searching from pointer+1 upward, modulo N_REQ.
  - Next cycle: GRANT=onehot(winner), state=GRANT, count=0, pointer=winner.
  - Arbitration latency is 1 cycle; no transfer happens in IDLE.
- GRANT (g = granted index):
  - FIFO_WEN = REQ_VALID[g] & ~FIFO_WFULL (combinational).
  - REQ_READY[g] = ~FIFO_WFULL; all other REQ_READY bits are 0.
  - FIFO_WDATA = REQ_DATA slice g (combinational mux, no added latency).
  - Each transfer increments count.
- Release conditions, evaluated at rising HCLK:
  - (a) a transfer occurs and count+1 == BURST_MAX; or
  - (b) REQ_VALID[g]=0 (requester gap ends the burst).
- On release:
  - If any REQ_VALID is high, excluding g in case (b), re-arbitrate from g+1 and load the new grant directly (GRANT->GRANT, zero idle cycles, count=0).
  - Otherwise go to IDLE with GRANT=0.
  - In case (a), g may win again only if no other requester is valid.
- FIFO_WFULL high: no transfer, count holds, grant holds indefinitely. A full FIFO never releases a grant.
- WFULL deasserting: the transfer resumes in the same cycle.
- BURST_MAX=1: re-arbitrate after every word, giving strict per-word round robin.
- Reset asserted mid-burst: the grant is dropped, any word in that cycle is not written, and the pointer is restored to N_REQ-1.
- Fairness: with all requesters continuously valid and the FIFO never full, each requester gets exactly BURST_MAX words per N_REQ*BURST_MAX cycles.
- Invariants: GRANT is always one-hot or zero; FIFO_WEN implies ~FIFO_WFULL; at most one REQ_READY bit is high.

Decomposition:
- Shared package/header holds:
  - state encodings (ST_IDLE, ST_GRANT);
  - the function for clog2 of BURST_MAX+1 (count width);
  - a rotate-priority helper function.
- One sub-module: fifo_rr_pick.
  - Combinational: takes a request vector and a pointer, returns a one-hot winner and a found flag.
  - Reused for the IDLE arbitration and the GRANT->GRANT re-arbitration.

Test Plan:
- Reset then a single requester: REQ_VALID=4'b0010 with 3 words 0xAAAABBBB, 0xBBBBCCCC, 0xCCCCDDDD.
  - Expect GRANT=0010 one cycle after VALID and 3 consecutive FIFO_WEN pulses with matching data.
  - VALID then drops, so expect IDLE and BUSY=0.
- All 4 valid continuously, BURST_MAX=4, FIFO never full.
  - Expect grants in order 0,1,2,3,0, each exactly 4 FIFO_WEN cycles.
  - Expect no idle cycles between bursts.
- WFULL forced high for 5 cycles mid-burst after word 2 of requester 1.
  - Expect FIFO_WEN=0 and REQ_READY=0 for those 5 cycles with GRANT unchanged.
  - Expect words 3-4 written afterwards, then the grant moves to requester 2.
- Requester 2 drops VALID after 1 word while requester 0 is valid.
  - Expect release and GRANT=0001 on the next cycle.
  - Expect pointer fairness to continue from 0, so requester 1 is next if valid.
- HRESETn pulsed low for 1 cycle during a burst of requester 3.
  - Expect GRANT=0 and no FIFO_WEN in the reset cycle.
  - Expect requester 0 to win first after reset.
- End-to-end with mfp_fifo_dc (ADDR_WIDTH=3) and read clock at 20 ns.
  - 2 requesters push 8 words each.
  - The read side must return all 16 words, each requester's data in order, with no loss while WFULL toggles.
